// File: rtl/eviction_drain_queue_if.sv
// Bundles the writeback push, upstream read and physical-memory ports of eviction_drain_queue.
// The master side is the environment: it offers lines and reads, and it also answers as memory.
interface eviction_drain_queue_if;
    logic         wb_valid;
    logic [15:0]  wb_addr;
    logic [127:0] wb_data;
    logic         wb_ready;
    logic         rd_req;
    logic [15:0]  rd_addr;
    logic         rd_resp;
    logic [127:0] rd_data;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [3:0]   count;

    modport master (
        output wb_valid, wb_addr, wb_data, rd_req, rd_addr, pmem_rdata, pmem_resp,
        input  wb_ready, rd_resp, rd_data, pmem_read, pmem_write, pmem_address, pmem_wdata, count
    );
    modport slave (
        input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, pmem_rdata, pmem_resp,
        output wb_ready, rd_resp, rd_data, pmem_read, pmem_write, pmem_address, pmem_wdata, count
    );
endinterface

// File: rtl/eviction_drain_queue.sv
// In-order writeback FIFO between an eviction stage and memory: coalesces repeat lines,
// serves upstream reads from queued lines, and otherwise drains oldest-first.
module eviction_drain_queue #(
    parameter int DEPTH       = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eviction_drain_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, READ_MEM, READ_HIT} state_e;

    state_e         state_q, state_d;
    logic [15:0]    addr_q [DEPTH];
    logic [15:0]    addr_d [DEPTH];
    logic [127:0]   data_q [DEPTH];
    logic [127:0]   data_d [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [3:0]     count_q, count_d;
    logic           pmem_read_q, pmem_read_d, pmem_write_q, pmem_write_d;
    logic [15:0]    pmem_address_q, pmem_address_d;
    logic [127:0]   pmem_wdata_q, pmem_wdata_d;
    logic           rd_resp_q, rd_resp_d;
    logic [127:0]   rd_data_q, rd_data_d;

    logic           cz_hit, rh_hit, wb_ready, push, alloc, pop, rd_act, rd_push_hit;
    logic [PW-1:0]  cz_idx;
    logic [127:0]   rh_data;

    function automatic logic line_eq(input logic [15:0] a, input logic [15:0] b);
        return a[15:OFFSET_BITS] == b[15:OFFSET_BITS];
    endfunction

    // Walk entries oldest to youngest so the youngest match wins; after an in-flight
    // head was re-allocated the same line can sit in the queue twice.
    always_comb begin
        cz_hit  = 1'b0;
        cz_idx  = '0;
        rh_hit  = 1'b0;
        rh_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = head_q + PW'(i);
            if (4'(i) < count_q) begin
                if (line_eq(addr_q[idx], bus.wb_addr) && !(i == 0 && state_q == DRAIN)) begin
                    cz_hit = 1'b1;
                    cz_idx = idx;
                end
                if (line_eq(addr_q[idx], bus.rd_addr)) begin
                    rh_hit  = 1'b1;
                    rh_data = data_q[idx];
                end
            end
        end
    end

    assign wb_ready    = rst_n && ((count_q < DEPTH_C) || cz_hit);
    assign push        = bus.wb_valid && wb_ready;
    assign alloc       = push && !cz_hit;
    assign rd_push_hit = push && line_eq(bus.wb_addr, bus.rd_addr);
    // rd_req is still held in the cycle its answer is presented; do not re-issue it.
    assign rd_act      = bus.rd_req && !rd_resp_q;

    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        rd_resp_d      = 1'b0;
        rd_data_d      = rd_data_q;
        pop            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q == DEPTH_C || (!rd_act && count_q != 4'd0)) begin
                    state_d        = DRAIN;
                    pmem_write_d   = 1'b1;
                    pmem_address_d = addr_q[head_q];
                    // A coalesce into the head on this very edge must reach memory too.
                    pmem_wdata_d   = (push && cz_hit && cz_idx == head_q) ? bus.wb_data
                                                                          : data_q[head_q];
                end else if (rd_act && (rh_hit || rd_push_hit)) begin
                    state_d   = READ_HIT;
                    rd_resp_d = 1'b1;
                    rd_data_d = rd_push_hit ? bus.wb_data : rh_data;
                end else if (rd_act) begin
                    state_d        = READ_MEM;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = bus.rd_addr;
                end
            end
            DRAIN: begin
                if (bus.pmem_resp) begin
                    state_d      = IDLE;
                    pmem_write_d = 1'b0;
                    pop          = 1'b1;
                end
            end
            READ_MEM: begin
                if (bus.pmem_resp) begin
                    state_d     = IDLE;
                    pmem_read_d = 1'b0;
                    rd_resp_d   = 1'b1;
                    rd_data_d   = bus.pmem_rdata;
                end
            end
            READ_HIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        tail_d = tail_q;
        head_d = pop ? head_q + PW'(1) : head_q;
        if (push && cz_hit) begin
            data_d[cz_idx] = bus.wb_data;
        end else if (alloc) begin
            addr_d[tail_q] = bus.wb_addr;
            data_d[tail_q] = bus.wb_data;
            tail_d         = tail_q + PW'(1);
        end
        count_d = count_q + {3'b0, alloc} - {3'b0, pop};
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            rd_resp_q      <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            rd_resp_q      <= rd_resp_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign bus.wb_ready     = wb_ready;
    assign bus.rd_resp      = rd_resp_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_eviction_drain_queue.sv
// Directed bench for eviction_drain_queue: the initial block plays eviction stage, reader
// and memory, with hand-computed expectations for each step.
module tb_eviction_drain_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   fails = 0;

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DE = {4{32'hEEEE_0005}};
    localparam logic [127:0] DF = {4{32'hFFFF_0006}};
    localparam logic [127:0] DG = {4{32'h1234_5678}};
    localparam logic [127:0] DH = {4{32'h7777_0008}};
    localparam logic [127:0] DX = {4{32'h5A5A_A5A5}};

    eviction_drain_queue_if bus ();

    eviction_drain_queue #(.DEPTH(4), .OFFSET_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_set(input logic [15:0] a, input logic [127:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    // Wait (bounded) for a write command, check it, answer it, and see it drop.
    task automatic drain_one(input string tag, input logic [15:0] a, input logic [127:0] d);
        for (int k = 0; k < 20 && !bus.pmem_write; k++) tick();
        chk({tag, "_write"}, bus.pmem_write, 1'b1);
        chk({tag, "_addr"}, bus.pmem_address, a);
        chk({tag, "_wdata"}, bus.pmem_wdata, d);
        chk({tag, "_noread"}, bus.pmem_read, 1'b0);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        chk({tag, "_drop"}, bus.pmem_write, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.rd_req = 1'b0;   bus.rd_addr = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        tick(); tick();
        chk("rst_ready", bus.wb_ready, 1'b0);
        chk("rst_count", bus.count, 4'd0);
        chk("rst_write", bus.pmem_write, 1'b0);
        chk("rst_resp", bus.rd_resp, 1'b0);
        chk("rst_addr", bus.pmem_address, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", bus.wb_ready, 1'b1);

        // Single push drains to memory
        push_set(16'h1230, DA);
        tick();
        bus.wb_valid = 1'b0;
        chk("t1_count1", bus.count, 4'd1);
        drain_one("t1", 16'h1230, DA);
        chk("t1_count0", bus.count, 4'd0);

        // Fill with the head write held open, then stall and coalesce
        push_set(16'h1000, {4{32'hD000_0000}}); tick();
        push_set(16'h1010, {4{32'hD000_0001}}); tick();
        push_set(16'h1020, {4{32'hD000_0002}}); tick();
        push_set(16'h1030, {4{32'hD000_0003}}); tick();
        push_set(16'h1040, {4{32'hD000_0004}}); #1;
        chk("t2_full_count", bus.count, 4'd4);
        chk("t2_full_ready", bus.wb_ready, 1'b0);
        tick();
        chk("t2_stall_count", bus.count, 4'd4);
        push_set(16'h1024, DX); #1;
        chk("t2_coal_ready", bus.wb_ready, 1'b1);
        tick();
        chk("t2_coal_count", bus.count, 4'd4);
        push_set(16'h1008, DB); #1;
        chk("t2_head_excl", bus.wb_ready, 1'b0);
        tick();
        bus.wb_valid = 1'b0;
        chk("t2_excl_count", bus.count, 4'd4);
        drain_one("t2a", 16'h1000, {4{32'hD000_0000}});
        drain_one("t2b", 16'h1010, {4{32'hD000_0001}});
        drain_one("t2c", 16'h1020, DX);
        drain_one("t2d", 16'h1030, {4{32'hD000_0003}});
        chk("t2_empty", bus.count, 4'd0);

        // Read hit on a queued line, ignoring the line offset
        push_set(16'h2040, DB); tick();
        bus.wb_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 16'h2048;
        tick();
        chk("t3_resp", bus.rd_resp, 1'b1);
        chk("t3_data", bus.rd_data, DB);
        chk("t3_noread", bus.pmem_read, 1'b0);
        chk("t3_nowrite", bus.pmem_write, 1'b0);
        bus.rd_req = 1'b0;
        tick();
        chk("t3_pulse", bus.rd_resp, 1'b0);
        drain_one("t3", 16'h2040, DB);

        // Read hit served by a same-cycle push into an empty queue
        push_set(16'h5000, DE);
        bus.rd_req = 1'b1; bus.rd_addr = 16'h5004;
        tick();
        bus.wb_valid = 1'b0;
        chk("t3s_resp", bus.rd_resp, 1'b1);
        chk("t3s_data", bus.rd_data, DE);
        chk("t3s_count", bus.count, 4'd1);
        bus.rd_req = 1'b0;
        tick();
        chk("t3s_pulse", bus.rd_resp, 1'b0);
        chk("t3s_noread", bus.pmem_read, 1'b0);
        drain_one("t3s", 16'h5000, DE);

        // Read miss goes to memory ahead of the pending write
        push_set(16'h4000, DF); tick();
        bus.wb_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 16'h3000;
        tick();
        chk("t4_read", bus.pmem_read, 1'b1);
        chk("t4_nowrite", bus.pmem_write, 1'b0);
        chk("t4_addr", bus.pmem_address, 16'h3000);
        bus.pmem_rdata = DG; bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        chk("t4_resp", bus.rd_resp, 1'b1);
        chk("t4_data", bus.rd_data, DG);
        chk("t4_read_drop", bus.pmem_read, 1'b0);
        bus.rd_req = 1'b0;
        tick();
        chk("t4_pulse", bus.rd_resp, 1'b0);
        drain_one("t4", 16'h4000, DF);

        // Same line pushed while its head write is in flight gets a new entry
        push_set(16'h1230, DA); tick();
        bus.wb_valid = 1'b0;
        tick();
        chk("t5_inflight", bus.pmem_write, 1'b1);
        push_set(16'h1230, DC); #1;
        chk("t5_ready", bus.wb_ready, 1'b1);
        tick();
        bus.wb_valid = 1'b0;
        chk("t5_count", bus.count, 4'd2);
        chk("t5_wdata_held", bus.pmem_wdata, DA);
        drain_one("t5a", 16'h1230, DA);
        drain_one("t5b", 16'h1230, DC);
        chk("t5_empty", bus.count, 4'd0);

        // Reset in the middle of a drain
        push_set(16'h7000, DH); tick();
        bus.wb_valid = 1'b0;
        tick();
        chk("t6_inflight", bus.pmem_write, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("t6_write", bus.pmem_write, 1'b0);
        chk("t6_count", bus.count, 4'd0);
        chk("t6_addr", bus.pmem_address, 16'h0);
        chk("t6_wdata", bus.pmem_wdata, 128'h0);
        chk("t6_ready", bus.wb_ready, 1'b0);
        rst_n = 1'b1;
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        chk("t6_late_count", bus.count, 4'd0);
        chk("t6_late_read", bus.pmem_read, 1'b0);
        tick(); tick(); tick();
        chk("t6_idle_write", bus.pmem_write, 1'b0);
        chk("t6_idle_resp", bus.rd_resp, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
